// File: rtl/fp_norm_pack.sv
// Normalise-and-pack back end: shifts a raw mantissa one bit per cycle until the
// hidden bit is set, then packs an IEEE-754 single word with overflow/underflow flags.
module fp_norm_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   sign_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [MAN_W+1:0]       mant_in,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int MW = MAN_W + 2;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  state_t                 state_q, state_d;
  logic                   s_q, s_d;
  logic [EXP_W:0]         e_q, e_d;
  logic [MW-1:0]          m_q, m_d;
  logic                   zero_q, zero_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [EXP_W+MAN_W:0]   result_q, result_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic [EXP_W:0]         e_inc;

  assign e_inc = e_q + EONE;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    e_d         = e_q;
    m_d         = m_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    result_d    = result_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = sign_in;
          e_d     = {1'b0, exp_in};
          m_d     = mant_in;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        // One normalisation action per cycle; the exponent is one bit wider so it never wraps.
        if (m_q == '0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else if (e_q == EMAX) begin
          ovf_d   = 1'b1;
          state_d = PACK;
        end else if (m_q[MW-1]) begin
          m_d = m_q >> 1;
          e_d = e_inc;
          if (e_inc == EMAX) begin
            ovf_d   = 1'b1;
            state_d = PACK;
          end
        end else if (m_q[MW-2]) begin
          state_d = PACK;
        end else if (e_q <= EONE) begin
          unf_d   = 1'b1;
          state_d = PACK;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - EONE;
        end
      end
      PACK: begin
        if (zero_q || unf_q)
          result_d = {s_q, {(EXP_W+MAN_W){1'b0}}};
        else if (ovf_q)
          result_d = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
          result_d = {s_q, e_q[EXP_W-1:0], m_q[MAN_W-1:0]};
        overflow_d  = ovf_q;
        underflow_d = unf_q;
        done_d      = 1'b1;
        zero_d      = 1'b0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e_q         <= e_d;
      m_q         <= m_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
